// File: rtl/i2s_pkg.sv
// Shared I2S constants and helpers used by the transmitter and the receiver.
package i2s_pkg;

  localparam int unsigned I2S_DATA_W  = 16;
  localparam int unsigned I2S_CLK_DIV = 4;
  localparam int unsigned I2S_SLOTS   = 2 * I2S_DATA_W;

  function automatic int unsigned i2s_slots(input int unsigned data_w);
    return 2 * data_w;
  endfunction

  // Word select leads the data by one bit: high from the last left slot to the second-last right slot.
  function automatic logic i2s_ws_right(input int unsigned slot, input int unsigned data_w);
    return (slot >= data_w - 1) && (slot <= 2 * data_w - 2);
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S bit clock divider: bit_clk toggles every CLK_DIV clk cycles; o_fall marks the cycle whose edge drops bit_clk.
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int unsigned CLK_DIV = I2S_CLK_DIV
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_bit_clk,
  output logic o_fall
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] r_div;
  logic       r_bit_clk;
  logic       w_wrap;

  assign w_wrap = (r_div == DIV_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div     <= '0;
      r_bit_clk <= 1'b0;
    end else if (w_wrap) begin
      r_div     <= '0;
      r_bit_clk <= ~r_bit_clk;
    end else begin
      r_div <= r_div + 8'd1;
    end
  end

  assign o_bit_clk = r_bit_clk;
  assign o_fall    = w_wrap && r_bit_clk;

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one-deep holding register feeding an MSB-first stereo frame shifter.
// Optional underrun_count output is enabled by defining I2S_TX_UNDERRUN_CNT_EN.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W  = I2S_DATA_W,
  parameter int unsigned CLK_DIV = I2S_CLK_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] left_data,
  input  logic [DATA_W-1:0] right_data,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              bit_clk,
  output logic              lr_clk,
  output logic              sdout,
`ifdef I2S_TX_UNDERRUN_CNT_EN
  output logic [15:0]       underrun_count,
`endif
  output logic              underrun
);

  localparam int unsigned SLOTS  = i2s_slots(DATA_W);
  localparam int unsigned SW     = $clog2(SLOTS);
  localparam logic [SW-1:0] S_LAST = SW'(SLOTS - 1);

  logic              w_fall;
  logic              w_frame_start;
  logic              w_accept;
  logic [SW-1:0]     w_s_next;
  logic [SLOTS-1:0]  w_frame;

  logic [SW-1:0]     r_slot;
  logic [SLOTS-1:0]  r_shift;
  logic [DATA_W-1:0] r_hold_l;
  logic [DATA_W-1:0] r_hold_r;
  logic              r_full;
  logic              r_sdout;
  logic              r_lr;
  logic              r_underrun;

  i2s_clk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_gen (
    .i_clk    (clk),
    .i_rst    (rst),
    .o_bit_clk(bit_clk),
    .o_fall   (w_fall)
  );

  assign w_s_next      = (r_slot == S_LAST) ? '0 : r_slot + 1'b1;
  assign w_frame_start = w_fall && (r_slot == S_LAST);
  assign w_accept      = sample_valid && !r_full;
  assign w_frame       = r_full ? {r_hold_l, r_hold_r} : '0;

  // Load has priority only when the holder is full, so a same-cycle accept lands for the following frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot     <= S_LAST;
      r_shift    <= '0;
      r_hold_l   <= '0;
      r_hold_r   <= '0;
      r_full     <= 1'b0;
      r_sdout    <= 1'b0;
      r_lr       <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_frame_start && !r_full;
      if (w_fall) begin
        r_slot <= w_s_next;
        r_lr   <= i2s_ws_right(32'(w_s_next), DATA_W);
        if (w_frame_start) begin
          r_sdout <= w_frame[SLOTS-1];
          r_shift <= {w_frame[SLOTS-2:0], 1'b0};
        end else begin
          r_sdout <= r_shift[SLOTS-1];
          r_shift <= {r_shift[SLOTS-2:0], 1'b0};
        end
      end
      if (w_frame_start && r_full) begin
        r_full <= 1'b0;
      end else if (w_accept) begin
        r_full   <= 1'b1;
        r_hold_l <= left_data;
        r_hold_r <= right_data;
      end
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] r_underrun_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_underrun_count <= '0;
    end else if (w_frame_start && !r_full && (r_underrun_count != '1)) begin
      r_underrun_count <= r_underrun_count + 16'd1;
    end
  end

  assign underrun_count = r_underrun_count;
`endif

  assign sample_ready = !r_full;
  assign sdout        = r_sdout;
  assign lr_clk       = r_lr;
  assign underrun     = r_underrun;

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 16: bits per channel sample.
REQ-002 SHALL have parameter CLK_DIV, default 4: clk cycles per bit_clk half-period; legal range 2..255.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 left_data  input  DATA_W  left sample, two's complement.
REQ-006 right_data  input  DATA_W  right sample, two's complement.
REQ-007 sample_valid  input  1  left_data and right_data are valid.
REQ-008 sample_ready  output  1  holding register empty; a sample is accepted when sample_valid && sample_ready.
REQ-009 bit_clk  output  1  generated I2S serial clock.
REQ-010 lr_clk  output  1  I2S word select; 0 = left, 1 = right.
REQ-011 sdout  output  1  I2S serial data.
REQ-012 underrun  output  1  one-clk pulse when a frame starts with no sample held.

Function
REQ-013 Divider SHALL count 0..CLK_DIV-1, toggle bit_clk and wrap at CLK_DIV-1, giving a bit_clk period of 2*CLK_DIV clk.
REQ-014 A falling-edge event is the clk cycle in which bit_clk toggles 1->0; sdout, lr_clk and the slot counter SHALL update in that same cycle, so all are registered and change together with the fall.
REQ-015 Slot counter s SHALL run 0..2*DATA_W-1, increment on each falling-edge event, and wrap from 2*DATA_W-1 to 0.
REQ-016 At slot s, sdout SHALL be frame_left[DATA_W-1-s] for s < DATA_W, else frame_right[2*DATA_W-1-s] (MSB first).
REQ-017 lr_clk SHALL be 1 for s in DATA_W-1..2*DATA_W-2 and 0 otherwise, i.e. one bit_clk ahead of the data (standard I2S).
REQ-018 Holding register: on accept, it SHALL capture both samples and drop sample_ready on the next cycle.
REQ-019 On the falling-edge event entering s=0, a full holding register SHALL be loaded into the frame shift registers and emptied, with sample_ready=1 on the next cycle.
REQ-020 On the falling-edge event entering s=0 with the holding register empty, the frame SHALL be transmitted as all zeros and underrun SHALL pulse for exactly that cycle.
REQ-021 If an accept and the s=0 load fall in the same cycle, the accept SHALL win the holding register only for the next frame (no bypass); the current frame is therefore an underrun.
REQ-022 sample_valid while sample_ready=0 SHALL be ignored; no sample is overwritten.

Reset
REQ-023 While rst=1: bit_clk=0, lr_clk=0, sdout=0, underrun=0, sample_ready=1, divider=0, s=2*DATA_W-1, holding and frame registers cleared.
REQ-024 rst asserted mid-frame SHALL abort the frame and discard any held sample; outputs take reset values on the next clk edge.
REQ-025 After rst deasserts, the first rising edge of bit_clk SHALL occur CLK_DIV cycles later and the first falling edge (entering s=0) 2*CLK_DIV cycles later.

Configuration
REQ-026 Macro I2S_TX_UNDERRUN_CNT_EN defined: an additional output underrun_count [15:0] SHALL increment on each underrun pulse, saturate at 16'hFFFF, and reset to 0.
REQ-027 Macro undefined: the underrun_count port and its counter SHALL be absent; all other behaviour is unchanged.

Structure
REQ-028 Package i2s_pkg SHALL hold the default DATA_W and CLK_DIV constants and the slot-count constant 2*DATA_W, shared with the receiver.
REQ-029 Sub-module i2s_clk_gen SHALL contain the divider and output bit_clk plus a one-cycle fall strobe; i2s_tx instantiates it once.

Verification (DATA_W=16, CLK_DIV=2)
REQ-030 After reset, accept left=16'hA5F0, right=16'h0F0F before the first fall -> sdout over s=0..31 = A5F0 then 0F0F MSB first; lr_clk=1 exactly on s=15..30.
REQ-031 Measure the clocks -> bit_clk period 4 clk; first fall 4 clk after reset release; frame 128 clk.
REQ-032 No sample supplied -> sdout all 0 for the frame, one underrun pulse per frame at entry to s=0.
REQ-033 Continuous valid -> ready drops 1 cycle after accept and returns 1 cycle after each s=0 load; no underrun over 4 frames; each frame carries the next sample in order.
REQ-034 Assert rst at s=10 -> next cycle all outputs 0, sample_ready=1; the next frame after release sends zeros with an underrun.
REQ-035 With I2S_TX_UNDERRUN_CNT_EN, 3 empty frames -> underrun_count=3; preloaded near-max counter holds at 16'hFFFF.
